queue_uart_tx: RTL
==================

Name: queue_uart_tx

Overview:
- Drain stage placed directly downstream of the 16-entry x 16-bit queue.
- Pops one 16-bit word at a time and serialises it onto a UART TX line as two 8N1 bytes, low byte first.
- Paced by a clock divider; new words are started only when the queue reports non-empty and tx_en is high.
- Honours the queue's timing: its dout is registered off the read address, and its empty flag lags a pop by two clock edges.

Parameters:
- CLK_DIV, 434, clocks per UART bit (50 MHz / 115200). Legal range 4..65535.
- DIV_W, 16, width of the bit-period counter. Must satisfy 2^DIV_W > CLK_DIV.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- q_empty  in  1  queue empty flag.
- q_dout  in  16  queue read data (registered by the queue, valid while its read address is stable).
- q_pop  out  1  pop strobe to the queue, registered, one cycle wide.
- tx_en  in  1  start permission for new words; an in-flight word always completes.
- tx  out  1  serial output, idle high.
- busy  out  1  high while a word is captured or being shifted.

Behaviour:
- Reset (reset low, asynchronous):
  - tx=1, q_pop=0, busy=0.
  - state=IDLE; bit counter, byte index and divider cleared.
  - Takes effect immediately, including mid-frame. The partial frame is abandoned and the popped word is lost, not re-queued.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - If tx_en=1 and q_empty=0 at a rising edge: word<=q_dout, q_pop<=1, busy<=1, byte_idx<=0, divider<=0, state<=START.
  - Otherwise hold, with tx=1 and q_pop=0.
- q_pop: forced to 0 on the edge after it rises, so it is exactly one cycle wide. Exactly one pop per word.
- START:
  - tx=0 for CLK_DIV cycles.
  - Then bit_idx<=0, state<=DATA.
- DATA:
  - tx = selected byte bit[bit_idx], LSB first, each bit held CLK_DIV cycles.
  - byte_idx=0 selects word[7:0]; byte_idx=1 selects word[15:8].
  - After bit 7, state<=STOP.
- STOP:
  - tx=1 for CLK_DIV cycles.
  - If byte_idx=0: byte_idx<=1, state<=START. No idle gap between the two bytes.
  - If byte_idx=1: busy<=0, state<=IDLE.
- Word frame length: exactly 20*CLK_DIV cycles from the first START cycle to the last STOP cycle.
- Back-to-back words:
  - IDLE samples q_empty on the first cycle after the STOP that ends a word.
  - Words therefore follow with a single idle-high cycle between frames.
  - The queue's empty/dout are settled by then, since its 2-edge lag is shorter than one frame (guaranteed by CLK_DIV>=4).
- Capture source: q_dout is taken in the same edge that raises q_pop, so the captured word is the current head entry, not the next one.
- tx_en:
  - Sampled only in IDLE.
  - Dropping tx_en mid-word has no effect until the word completes.
- Simultaneous events: a queue push during a word has no effect on the block. q_empty changes are ignored outside IDLE.
- Divider: counts 0..CLK_DIV-1, then wraps to 0 at each bit boundary. It is cleared when leaving IDLE.
- The block issues no pop while q_empty=1, so the queue's read pointer can never pass its write pointer.

Test Plan:
- Single word, CLK_DIV=4. Push 16'hA55A, tx_en=1.
  - Required: one q_pop pulse.
  - tx shows 0,01011010 (LSB-first 0x5A),1 then 0,10100101 (0xA5),1, 4 cycles per bit.
  - busy high for 80 cycles, then tx=1.
- Back-to-back, CLK_DIV=4. Push 16'h1234 and 16'hBEEF.
  - Required: bytes 34,12,EF,BE in order, exactly 2 q_pop pulses, one idle cycle between words.
  - Afterwards empty=1 and no third pop.
- tx_en gating. tx_en=0 with 3 words queued.
  - Required: no q_pop and tx=1 for 200 cycles.
  - Raise tx_en: all 3 words sent.
  - Drop tx_en mid word 2: word 2 completes, word 3 is not started.
- Reset mid-frame, CLK_DIV=4. Assert reset during DATA bit 3 of the high byte.
  - Required: tx=1 and busy=0 asynchronously, before the next clk edge.
  - After release with queue empty, tx stays high.
- Full queue drain. Fill the queue with 16 words 16'h0000..16'h000F, CLK_DIV=4.
  - Required: 32 bytes 00,00,01,00,...,0F,00 in order, then 16 pops total.
  - q_empty=1 and the block idles.
- Large divider, CLK_DIV=434. Single word 16'h00FF.
  - Required: each bit measured at exactly 434 cycles, frame 8680 cycles.

Source files
------------

// File: rtl/queue_uart_tx.sv
// Drains a 16-bit word queue onto an 8N1 UART line, low byte first.
// One pop per word; the word is captured on the same edge that raises q_pop.
module queue_uart_tx #(
  parameter int CLK_DIV = 434,
  parameter int DIV_W   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        q_empty,
  input  logic [15:0] q_dout,
  output logic        q_pop,
  input  logic        tx_en,
  output logic        tx,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  state_t           state_q, state_d;
  logic [15:0]      word_q, word_d;
  logic             byte_idx_q, byte_idx_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             pop_q, pop_d;
  logic             busy_q, busy_d;
  logic             bit_end;
  logic [7:0]       cur_byte;

  assign bit_end  = (div_q == DIV_LAST);
  assign cur_byte = byte_idx_q ? word_q[15:8] : word_q[7:0];
  assign q_pop    = pop_q;
  assign busy     = busy_q;

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    byte_idx_d = byte_idx_q;
    bit_idx_d  = bit_idx_q;
    div_d      = div_q;
    pop_d      = 1'b0;
    busy_d     = busy_q;
    if (state_q != IDLE) begin
      div_d = bit_end ? '0 : div_q + DIV_W'(1);
    end
    case (state_q)
      IDLE: begin
        div_d = '0;
        // q_empty and tx_en only matter here; a started word always runs to completion
        if (tx_en && !q_empty) begin
          word_d     = q_dout;
          pop_d      = 1'b1;
          busy_d     = 1'b1;
          byte_idx_d = 1'b0;
          state_d    = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!byte_idx_q) begin
            byte_idx_d = 1'b1;
            state_d    = START;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    case (state_q)
      START:   tx = 1'b0;
      DATA:    tx = cur_byte[bit_idx_q];
      default: tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      byte_idx_q <= 1'b0;
      bit_idx_q  <= '0;
      div_q      <= '0;
      pop_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      div_q      <= div_d;
      pop_q      <= pop_d;
      busy_q     <= busy_d;
    end
  end

  // Word holding register carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

endmodule
